// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide unit: fixed-latency mult (MULT_CYCLES) and div (DIV_CYCLES), results commit at once.
// Divider present only when MDU_DIV_EN is defined; otherwise div/divu are no-ops.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

`ifdef MDU_DIV_EN
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_DIVU = 3'd3;
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
`else
  typedef enum logic [1:0] {IDLE, MUL} state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      res_q, res_d;
  logic             wr_q, wr_d;
  logic             done_q, done_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  logic [63:0] a_sx, b_sx, prod_s, prod_u;

  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'b0, A} * {32'b0, B};

`ifdef MDU_DIV_EN
  // Sign-magnitude divide: avoids the INT_MIN / -1 overflow case in native signed division.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  always_comb begin
    a_neg  = (op == OP_DIV) & A[31];
    b_neg  = (op == OP_DIV) & B[31];
    a_mag  = a_neg ? -A : A;
    b_mag  = b_neg ? -B : B;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d = MUL;
              cnt_d   = MULT_CNT;
              res_d   = (op == OP_MULT) ? prod_s : prod_u;
              wr_d    = 1'b1;
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              state_d = DIV;
              cnt_d   = DIV_CNT;
              res_d   = {rem, quo};
              wr_d    = (B != 32'd0);
            end
`endif
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      default: begin
        // Result was latched at issue; this only times the commit.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (wr_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed vector table, reset-abort sequence and random traffic against a cycle-schedule model.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] HI, LO;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: architectural HI/LO plus the edge number at which the in-flight op commits.
  int          e = 0;
  int          commit_e = -1;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (edge %0d)", name, act, exp, e);
    end
  endtask

  task automatic model_issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0, 3'd1: begin
        if (o == 3'd0) r = sa * sb;
        else           r = ua * ub;
        p_hi = r[63:32]; p_lo = r[31:0]; p_wr = 1'b1;
        commit_e = e + MC;
      end
      3'd2, 3'd3: if (DIV_EN) begin
        if (b == 32'd0) p_wr = 1'b0;
        else begin
          if (o == 3'd2) begin
            sq = sa / sb; sr = sa % sb;
            r = sq; p_lo = r[31:0];
            r = sr; p_hi = r[31:0];
          end else begin
            uq = ua / ub; ur = ua % ub;
            p_lo = uq[31:0]; p_hi = ur[31:0];
          end
          p_wr = 1'b1;
        end
        commit_e = e + DC;
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic tick(input bit s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit exp_done, was_busy;
    start = s; op = o; A = a; B = b;
    @(posedge clk);
    e++;
    was_busy = (e - 1 < commit_e);
    exp_done = (e == commit_e);
    if (exp_done && p_wr) begin
      m_hi = p_hi;
      m_lo = p_lo;
    end
    if (s && !was_busy) model_issue(o, a, b);
    #1;
    chk("busy", 32'(busy), 32'(e < commit_e));
    chk("done", 32'(done), 32'(exp_done));
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [31:0] exp_hi, exp_lo;
    int          exp_busy;
    bit          exp_done;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int cnt;
    logic [31:0] ra, rb;

    tbl[0] = '{3'd0, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, MC, 1'b1};
    tbl[1] = '{3'd1, 32'd3, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFD, MC, 1'b1};
`ifdef MDU_DIV_EN
    tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC, 1'b1};
    tbl[3] = '{3'd3, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, DC, 1'b1};
    tbl[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC, 1'b1};
    tbl[5] = '{3'd4, 32'h12345678, 32'd0, 32'h12345678, 32'h80000000, 0, 1'b0};
`else
    tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'h00000002, 32'hFFFFFFFD, 0, 1'b0};
    tbl[3] = '{3'd3, 32'hFFFFFFF9, 32'd0, 32'h00000002, 32'hFFFFFFFD, 0, 1'b0};
    tbl[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFD, 0, 1'b0};
    tbl[5] = '{3'd4, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFD, 0, 1'b0};
`endif
    tbl[6] = '{3'd5, 32'h9ABCDEF0, 32'd0, 32'h12345678, 32'h9ABCDEF0, 0, 1'b0};
    tbl[7] = '{3'd6, 32'hDEADBEEF, 32'h1, 32'h12345678, 32'h9ABCDEF0, 0, 1'b0};
    tbl[8] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC, 1'b1};

    reset = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Directed vectors; idle-cycle operands are randomised to show they are ignored.
    foreach (tbl[i]) begin
      tick(1'b1, tbl[i].o, tbl[i].a, tbl[i].b);
      cnt = 0;
      while (busy && cnt < 40) begin
        cnt++;
        tick(1'b0, 3'd0, $urandom, $urandom);
      end
      chk($sformatf("tbl%0d_busy_cycles", i), 32'(cnt), 32'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].exp_done));
      chk($sformatf("tbl%0d_HI", i), HI, tbl[i].exp_hi);
      chk($sformatf("tbl%0d_LO", i), LO, tbl[i].exp_lo);
      tick(1'b0, 3'd0, 32'd0, 32'd0);
    end

    // mthi/mtlo on consecutive cycles.
    tick(1'b1, 3'd4, 32'h12345678, 32'd0);
    tick(1'b1, 3'd5, 32'h9ABCDEF0, 32'd0);
    chk("mtx_HI", HI, 32'h12345678);
    chk("mtx_LO", LO, 32'h9ABCDEF0);
    chk("mtx_busy", 32'(busy), 32'd0);

    // Starts while busy are ignored, then a back-to-back issue on the done cycle.
    tick(1'b1, 3'd1, 32'h0000FFFF, 32'h00010000);
    repeat (MC - 1) tick(1'b1, 3'd4, 32'hBAD0BAD0, 32'hBAD0BAD0);
    tick(1'b0, 3'd0, 32'd0, 32'd0);
    tick(1'b1, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (MC + 1) tick(1'b0, 3'd0, $urandom, $urandom);

    // Reset in the third busy cycle aborts the multiply.
    tick(1'b1, 3'd0, 32'd3, 32'hFFFFFFFF);
    tick(1'b0, 3'd0, 32'd0, 32'd0);
    tick(1'b0, 3'd0, 32'd0, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_HI", HI, 32'd0);
    chk("abort_LO", LO, 32'd0);
    m_hi = '0; m_lo = '0; commit_e = -1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    tick(1'b1, 3'd1, 32'h00000007, 32'h00000006);
    repeat (MC + 2) tick(1'b0, 3'd0, 32'd0, 32'd0);
    chk("after_abort_LO", LO, 32'd42);

    // Random traffic with corner operands mixed in.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: ra = 32'hFFFFFFFF;
        2: ra = 32'd0;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'hFFFFFFFF;
        1: rb = 32'd0;
        2: rb = $urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      tick(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, rb);
    end
    repeat (DC + 2) tick(1'b0, 3'd0, 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration in cycles for mult/multu (legal range 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration in cycles for div/divu (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit, E-stage issue strobe for an MDU instruction.
REQ-006 SHALL have port op, input, 3 bits, operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 are no-ops.
REQ-007 SHALL have port A, input, 32 bits, forwarded rs operand.
REQ-008 SHALL have port B, input, 32 bits, forwarded rt operand.
REQ-009 SHALL have port busy, output, 1 bit, high while a mult or div operation is in flight; feeds the stall unit.
REQ-010 SHALL have port done, output, 1 bit, one-cycle pulse when a mult or div result commits to HI/LO.
REQ-011 SHALL have port HI, output, 32 bits, architectural HI register.
REQ-012 SHALL have port LO, output, 32 bits, architectural LO register.

Function
REQ-013 SHALL implement three states: IDLE, MUL, DIV.
REQ-014 SHALL sample start only in IDLE; start while busy is ignored, and the stall unit guarantees this does not occur.
REQ-015 On start with op 0/1 at edge k, SHALL latch the 64-bit product, signed for op 0 and unsigned for op 1, enter MUL, and load the counter with MULT_CYCLES.
REQ-016 On start with op 2/3 at edge k, SHALL latch quotient/remainder, signed for op 2 and unsigned for op 3, enter DIV, and load the counter with DIV_CYCLES.
REQ-017 Counter SHALL decrement each edge in MUL/DIV; at the edge where the counter equals 1, SHALL return to IDLE and write HI/LO.
REQ-018 Latency SHALL be fixed: busy high for exactly N cycles following edge k; HI/LO new values visible after edge k+N; done high for the single cycle after edge k+N.
REQ-019 Product SHALL commit with HI = bits 63:32 and LO = bits 31:0.
REQ-020 Division SHALL commit with LO = quotient truncated toward zero and HI = remainder carrying the sign of the dividend.
REQ-021 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 Divide by zero SHALL run the full DIV_CYCLES, pulse done, and leave HI/LO unchanged.
REQ-023 mthi/mtlo with start in IDLE SHALL write A into HI/LO respectively at that same edge, with no busy and no done.
REQ-024 op 6/7 with start SHALL have no effect.
REQ-025 HI/LO SHALL hold their values during MUL/DIV until commit; reads during busy return the old values.
REQ-026 Operands captured at the start edge SHALL be the only ones used; later changes to A/B SHALL NOT affect the result.

Reset
REQ-027 reset low SHALL immediately force state IDLE, counter 0, busy 0, done 0, HI 0, LO 0, independent of clk.
REQ-028 reset asserted mid-operation SHALL abort the operation; no commit and no done pulse shall follow release.
REQ-029 The first start after reset release SHALL be honoured on the first rising edge at which reset is high.

Configuration
REQ-030 Macro MDU_DIV_EN defined: div/divu SHALL be fully supported per REQ-016, REQ-020 to REQ-022.
REQ-031 Macro MDU_DIV_EN undefined: divider logic and the DIV state SHALL be absent; start with op 2/3 SHALL behave as a no-op (no busy, no done, HI/LO unchanged).

Verification
REQ-032 A=3, B=0xFFFFFFFF, op=0 start -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFD, done one cycle.
REQ-033 Same operands, op=1 -> HI=0x00000002, LO=0xFFFFFFFD after 5 busy cycles.
REQ-034 A=0xFFFFFFF9 (-7), B=2, op=2 -> busy 10 cycles, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); then B=0, op=3 -> HI/LO unchanged, done pulses after 10 cycles.
REQ-035 op=4 A=0x12345678 then op=5 A=0x9ABCDEF0 on consecutive cycles -> HI=0x12345678, LO=0x9ABCDEF0, busy never high.
REQ-036 Start mult, assert reset low in the 3rd busy cycle -> busy/HI/LO immediately 0, no done after release; a new start completes normally.
REQ-037 Build without MDU_DIV_EN, op=2 start -> busy stays 0, HI/LO unchanged.
